sha_padder: RTL and testbench
=============================

Name: sha_padder

Overview:
- Upstream feeder for the SHA compression engine.
- Accepts a message as a stream of big-endian 32-bit words and applies FIPS 180-4 padding: 0x80 marker, zero fill, and a bit-length field.
- Emits complete 512-bit blocks (SHA-1/224/256) or 1024-bit blocks (SHA-384/512/512_224/512_256) on a valid/ready handshake, with mode and new_msg attached.
- Holds one block buffer; the input stalls while a block is pending.

Parameters:
- LEN_W, 64, width of the internal byte counter. The bit length is byte count << 3. Upper bits of the length field beyond LEN_W+3 are driven to zero.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  32  message word; first byte in [31:24]
- in_last  in  1  marks the final word of the message
- in_bytes  in  2  valid bytes in the last word (1..3); 0 = all 4 bytes. Ignored unless in_last.
- in_mode  in  sha::mode_t  hash mode; sampled on the first word of each message
- blk_valid  out  1  block available
- blk_ready  in  1  engine accepts the block
- blk_mode  out  sha::mode_t  mode of the current message
- blk_new_msg  out  1  set on the first block of a message
- blk_data  out  1024  block data
  - 512-bit modes: word k in [511-32k -: 32], bits [1023:512] = 0
  - 1024-bit modes: word k in [1023-32k -: 32]

Behaviour:
- Reset (rstn low at a clk edge):
  - in_ready=1, blk_valid=0, blk_new_msg=0, blk_data=0, blk_mode=sha1
  - word index, byte counter and FSM cleared to st_fill
  - Reset mid-message or mid-emit discards all state; no partial block is ever emitted.
- Block geometry:
  - N = 16 words (sha1/224/256) or 32 words (other modes).
  - Length field L = 2 words (512-bit) or 4 words (1024-bit); the top 64 bits of the 128-bit field are always 0.
- FSM states: st_fill, st_pad, st_len, st_emit.
- st_fill:
  - in_ready=1. Each accepted word is written at the word index; index increments; byte counter adds 4, or in_bytes (0→4) on the last word.
  - First word of a message latches in_mode and sets a pending new_msg flag.
  - Last word with in_bytes≠0: the valid bytes are kept, byte (in_bytes) is 0x80, the rest are zero. Index increments.
  - Last word with in_bytes=0: the next word written is 0x80000000.
  - Index reaching N with no last word → st_emit. Last word → st_pad.
- st_pad:
  - in_ready=0.
  - Writes the 0x80000000 word if still owed, then zero words one per cycle.
  - Continues until index == N-L → st_len.
  - If the marker leaves index > N-L, zero-fill to N → st_emit, then a second block of zeros up to N-L → st_len.
- st_len: writes the bit length into the last L words (most-significant word first) in a single cycle → st_emit.
- st_emit:
  - blk_valid=1; blk_data, blk_mode and blk_new_msg are held stable until blk_valid & blk_ready.
  - On handshake:
    - blk_new_msg clears for subsequent blocks.
    - The buffer is zeroed and the index is reset.
    - Next state is st_fill if the message is open or finished, or st_pad for an overflow second block.
  - blk_ready high without blk_valid has no effect.
  - After the final block, the byte counter is cleared.
- Latency:
  - Last data word to blk_valid is ≤ N+2 cycles.
  - A full non-last block emits one cycle after its 16th/32nd word.
- Empty message: a lone word with in_last=1 and in_bytes=0 means 4 bytes. Empty messages use the bypass-free path defined in the Optional Feature: no zero-length request exists at this interface.
- Mode change mid-message is ignored; the mode is fixed from the first word.

Optional Feature:
- SHA_PADDER_BYPASS_EN defined:
  - Adds input pad_bypass (1 bit), sampled with the first word.
  - When set, words are packed unpadded; no marker and no length field are added.
  - in_last must coincide with a word index of N-1. Otherwise an output err (1 bit, sticky until reset) rises and the partial block is dropped.
- Undefined: the pad_bypass and err ports do not exist; the padding path always applies.

Test Plan:
- sha256, single word 0x61626300 with in_last=1, in_bytes=3 → one block: w0=0x61626380, w1..w13=0, w14=0, w15=0x00000018, blk_new_msg=1.
- sha512, same "abc" word → 1024-bit block: w0=0x61626380, w1..w30=0, w31=0x00000018, blk_data[1023:992]=0x61626380.
- sha256, 14 full words (56 bytes) with last on word 14 → block 1: w14=0x80000000, w15=0, new_msg=1; block 2: zeros with w15=0x000001C0, new_msg=0.
- sha1, 32 full words then last word 0x11223344 with in_bytes=0 → blocks 1 and 2 carry data, new_msg only on block 1; block 3: w0=0x11223344, w1=0x80000000, w15=0x00000420.
- Backpressure: hold blk_ready=0 for 10 cycles → in_ready=0 and blk_data stable; the handshake releases and in_ready=1 the next cycle.
- Assert rstn=0 for one cycle mid-fill at word 7 → all outputs at reset values; a following new "abc" message produces the same block as the first test.

Source files
------------

// File: rtl/sha_padder_if.sv
// Hash-mode package and the padder's word-stream / block-output interface.
// pad_bypass and err exist only when SHA_PADDER_BYPASS_EN is defined.
package sha;

    typedef enum logic [2:0] {
        sha1,
        sha224,
        sha256,
        sha384,
        sha512,
        sha512_224,
        sha512_256
    } mode_t;

    // True for the SHA-384/512 family, which uses 1024-bit blocks.
    function automatic logic is_wide(mode_t m);
        return m inside {sha384, sha512, sha512_224, sha512_256};
    endfunction

endpackage

interface sha_padder_if;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic [1:0]    in_bytes;
    sha::mode_t    in_mode;

    logic          blk_valid;
    logic          blk_ready;
    sha::mode_t    blk_mode;
    logic          blk_new_msg;
    logic [1023:0] blk_data;

`ifdef SHA_PADDER_BYPASS_EN
    logic          pad_bypass;
    logic          err;
`endif

    modport master (
        output in_valid, in_data, in_last, in_bytes, in_mode, blk_ready,
        input  in_ready, blk_valid, blk_mode, blk_new_msg, blk_data
`ifdef SHA_PADDER_BYPASS_EN
        , output pad_bypass
        , input  err
`endif
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, in_mode, blk_ready,
        output in_ready, blk_valid, blk_mode, blk_new_msg, blk_data
`ifdef SHA_PADDER_BYPASS_EN
        , input  pad_bypass
        , output err
`endif
    );

endinterface

// File: rtl/sha_padder.sv
// FIPS 180-4 message padder: packs 32-bit words into 512/1024-bit blocks with
// marker, zero fill and bit length. Optional unpadded mode: SHA_PADDER_BYPASS_EN.
module sha_padder #(
    parameter int LEN_W = 64
) (
    input logic         clk,
    input logic         rstn,
    sha_padder_if.slave bus
);
    import sha::*;

    typedef enum logic [1:0] {
        st_fill,
        st_pad,
        st_len,
        st_emit
    } state_t;

    localparam logic [31:0] MARKER_WORD = 32'h8000_0000;

    state_t           state_q, state_d;
    logic [31:0]      buf_q [32];
    logic [31:0]      buf_d [32];
    logic [5:0]       idx_q, idx_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    mode_t            mode_q, mode_d;
    logic             new_msg_q, new_msg_d;
    logic             open_q, open_d;     // message started, last word not yet seen
    logic             owed_q, owed_d;     // 0x80000000 marker word still to be written
    logic             ovf_q, ovf_d;       // a second padding-only block follows this one
`ifdef SHA_PADDER_BYPASS_EN
    logic             byp_q, byp_d;
    logic             err_q, err_d;
`endif

    mode_t            cur_mode;
    logic             wide;
    logic             wide_q;
    logic             byp_now;
    logic [5:0]       n_words;
    logic [5:0]       pad_end;
    logic [4:0]       last_i;
    logic [2:0]       last_bytes;
    logic [31:0]      last_word;
    logic [63:0]      bit_len;

    // The first word of a message decides geometry before mode_q has latched it.
    assign cur_mode   = (state_q == st_fill && !open_q) ? bus.in_mode : mode_q;
    assign wide       = is_wide(cur_mode);
    assign wide_q     = is_wide(mode_q);
    assign n_words    = wide ? 6'd32 : 6'd16;
    assign pad_end    = wide ? 6'd28 : 6'd14;
    assign last_i     = 5'(n_words - 6'd1);
    assign last_bytes = (bus.in_bytes == 2'd0) ? 3'd4 : {1'b0, bus.in_bytes};
    assign last_word  = (bus.in_data & ~(32'hFFFF_FFFF >> {bus.in_bytes, 3'b000}))
                      | (32'h0000_0080 << {2'd3 - bus.in_bytes, 3'b000});
    assign bit_len    = 64'({cnt_q, 3'b000});

`ifdef SHA_PADDER_BYPASS_EN
    assign byp_now = (state_q == st_fill && !open_q) ? bus.pad_bypass : byp_q;
    assign bus.err = err_q;
`else
    assign byp_now = 1'b0;
`endif

    // NOTE: every signal written here gets its default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        new_msg_d = new_msg_q;
        open_d    = open_q;
        owed_d    = owed_q;
        ovf_d     = ovf_q;
`ifdef SHA_PADDER_BYPASS_EN
        byp_d     = byp_q;
        err_d     = err_q;
`endif

        case (state_q)
            st_fill: begin
                if (bus.in_valid) begin
                    if (!open_q) begin
                        mode_d    = bus.in_mode;
                        new_msg_d = 1'b1;
                        open_d    = 1'b1;
`ifdef SHA_PADDER_BYPASS_EN
                        byp_d     = bus.pad_bypass;
`endif
                    end
                    cnt_d = cnt_q + LEN_W'(bus.in_last ? last_bytes : 3'd4);
                    buf_d[idx_q[4:0]] = (bus.in_last && bus.in_bytes != 2'd0 && !byp_now)
                                      ? last_word : bus.in_data;
                    idx_d = idx_q + 6'd1;

                    if (bus.in_last) begin
                        open_d = 1'b0;
                        if (byp_now) begin
                            if (idx_q == n_words - 6'd1) begin
                                state_d = st_emit;
                            end else begin
                                // Misaligned unpadded message: drop the partial block.
                                for (int k = 0; k < 32; k++) buf_d[k] = '0;
                                idx_d     = '0;
                                cnt_d     = '0;
                                new_msg_d = 1'b0;
`ifdef SHA_PADDER_BYPASS_EN
                                err_d     = 1'b1;
`endif
                            end
                        end else begin
                            owed_d  = (bus.in_bytes == 2'd0);
                            state_d = st_pad;
                        end
                    end else if (idx_q + 6'd1 == n_words) begin
                        state_d = st_emit;
                    end
                end
            end

            st_pad: begin
                if (idx_q == n_words) begin
                    state_d = st_emit;
                    ovf_d   = 1'b1;
                end else if (owed_q) begin
                    buf_d[idx_q[4:0]] = MARKER_WORD;
                    idx_d  = idx_q + 6'd1;
                    owed_d = 1'b0;
                end else if (idx_q == pad_end) begin
                    state_d = st_len;
                end else begin
                    buf_d[idx_q[4:0]] = '0;
                    idx_d = idx_q + 6'd1;
                    if (idx_q + 6'd1 == pad_end) state_d = st_len;
                end
            end

            st_len: begin
                if (wide) begin
                    buf_d[last_i - 5'd3] = '0;
                    buf_d[last_i - 5'd2] = '0;
                end
                buf_d[last_i - 5'd1] = bit_len[63:32];
                buf_d[last_i]        = bit_len[31:0];
                idx_d   = n_words;
                state_d = st_emit;
            end

            st_emit: begin
                if (bus.blk_ready) begin
                    for (int k = 0; k < 32; k++) buf_d[k] = '0;
                    idx_d     = '0;
                    new_msg_d = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = ovf_q ? st_pad : st_fill;
                    if (!ovf_q && !open_q) cnt_d = '0;
                end
            end

            default: state_d = st_fill;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= st_fill;
            idx_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= sha1;
            new_msg_q <= 1'b0;
            open_q    <= 1'b0;
            owed_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef SHA_PADDER_BYPASS_EN
            byp_q     <= 1'b0;
            err_q     <= 1'b0;
`endif
            // NOTE: the block buffer is reset too, because blk_data is driven
            // straight from it and must read zero out of reset.
            for (int k = 0; k < 32; k++) buf_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            new_msg_q <= new_msg_d;
            open_q    <= open_d;
            owed_q    <= owed_d;
            ovf_q     <= ovf_d;
`ifdef SHA_PADDER_BYPASS_EN
            byp_q     <= byp_d;
            err_q     <= err_d;
`endif
            for (int k = 0; k < 32; k++) buf_q[k] <= buf_d[k];
        end
    end

    assign bus.in_ready    = (state_q == st_fill);
    assign bus.blk_valid   = (state_q == st_emit);
    assign bus.blk_mode    = mode_q;
    assign bus.blk_new_msg = new_msg_q;

    // Word 0 sits in the most significant 32 bits of the active block width.
    always_comb begin
        bus.blk_data = '0;
        if (wide_q) begin
            for (int k = 0; k < 32; k++) bus.blk_data[1023 - 32*k -: 32] = buf_q[k];
        end else begin
            for (int k = 0; k < 16; k++) bus.blk_data[511 - 32*k -: 32] = buf_q[k];
        end
    end

endmodule

// File: tb/tb_sha_padder.sv
// Self-checking bench for sha_padder: table vectors, corner sequences and
// randomized messages against a byte-level FIPS 180-4 padding model.
module tb_sha_padder;
    import sha::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sha_padder_if bus ();

    sha_padder #(.LEN_W(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [1023:0] data;
        mode_t         mode;
        logic          new_msg;
    } blk_t;

    typedef struct {
        mode_t       mode;
        logic [31:0] data;
        logic [1:0]  bytes;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] wlast;
    } vec_t;

    int            checks   = 0;
    int            errors   = 0;
    int            rdy_mode = 1;     // 0: hold low, 1: always ready, 2: random
    blk_t          got[$];
    blk_t          rcv[$];
    logic [7:0]    msg[$];
    logic [1023:0] exp_blk[$];

    // Ready is chosen at the negedge; a block seen valid&ready here is taken at the next posedge.
    always @(negedge clk) begin
        case (rdy_mode)
            0:       bus.blk_ready = 1'b0;
            1:       bus.blk_ready = 1'b1;
            default: bus.blk_ready = 1'($urandom_range(0, 1));
        endcase
        if (rstn && bus.blk_valid && bus.blk_ready)
            got.push_back('{bus.blk_data, bus.blk_mode, bus.blk_new_msg});
    end

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(logic [1023:0] d, mode_t m, int k);
        return is_wide(m) ? d[1023 - 32*k -: 32] : d[511 - 32*k -: 32];
    endfunction

    function automatic logic [1023:0] put_word(logic [1023:0] d, mode_t m, int k, logic [31:0] w);
        logic [1023:0] r;
        r = d;
        if (is_wide(m)) r[1023 - 32*k -: 32] = w;
        else            r[511 - 32*k -: 32]  = w;
        return r;
    endfunction

    // Reference: append 0x80, zero-fill, append big-endian bit length, cut into blocks.
    task automatic build_model(input mode_t m);
        int            bb;
        int            ll;
        logic [7:0]    q[$];
        logic [63:0]   bl;
        logic [1023:0] d;
        bb = is_wide(m) ? 128 : 64;
        ll = is_wide(m) ? 16 : 8;
        q  = msg;
        bl = 64'(msg.size()) * 64'd8;
        q.push_back(8'h80);
        while (q.size() % bb != bb - ll) q.push_back(8'h00);
        for (int i = ll - 1; i >= 0; i--) q.push_back(i < 8 ? bl[8*i +: 8] : 8'h00);
        exp_blk.delete();
        for (int b = 0; b < q.size() / bb; b++) begin
            d = '0;
            for (int j = 0; j < bb; j++) d[bb*8 - 1 - 8*j -: 8] = q[b*bb + j];
            exp_blk.push_back(d);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb, input mode_t m);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_bytes = nb;
        bus.in_mode  = m;
        while (!bus.in_ready && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_msg(input mode_t m, input bit chk_full);
        int          n;
        int          nb;
        int          nw;
        logic [31:0] w;
        n  = (msg.size() + 3) / 4;
        nb = msg.size() % 4;
        nw = is_wide(m) ? 32 : 16;
        for (int i = 0; i < n; i++) begin
            w = $urandom();
            for (int j = 0; j < 4; j++)
                if (4*i + j < msg.size()) w[31 - 8*j -: 8] = msg[4*i + j];
            send_word(w, i == n - 1,
                      (i == n - 1) ? 2'(nb) : 2'($urandom_range(0, 3)),
                      (i == 0) ? m : mode_t'($urandom_range(0, 6)));
            if (chk_full && (i % nw == nw - 1) && i != n - 1)
                check("full_blk_latency", bus.blk_valid, 1'b1);
        end
    endtask

    task automatic wait_blocks(input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("block_count", got.size(), n);
    endtask

    task automatic run_msg(input mode_t m, input string name, input bit chk_full);
        blk_t b;
        build_model(m);
        send_msg(m, chk_full);
        wait_blocks(exp_blk.size());
        rcv.delete();
        for (int i = 0; i < exp_blk.size(); i++) begin
            if (got.size() == 0) break;
            b = got.pop_front();
            rcv.push_back(b);
            check($sformatf("%s_blk%0d_data", name, i), b.data, exp_blk[i]);
            check($sformatf("%s_blk%0d_mode", name, i), b.mode, m);
            check($sformatf("%s_blk%0d_new_msg", name, i), b.new_msg, i == 0);
        end
    endtask

    vec_t          vt[6];
    blk_t          b;
    logic [1023:0] exp_d;
    logic [1023:0] abc_blk;
    logic [1023:0] held;
    int            lat;
    int            nbytes;
    mode_t         rm;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.in_bytes = '0;
        bus.in_mode  = sha1;
`ifdef SHA_PADDER_BYPASS_EN
        bus.pad_bypass = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_blk_valid", bus.blk_valid, 1'b0);
        check("rst_new_msg", bus.blk_new_msg, 1'b0);
        check("rst_blk_data", bus.blk_data, '0);
        check("rst_blk_mode", bus.blk_mode, sha1);
        rstn = 1'b1;
        @(negedge clk);

        // Single-word messages: {mode, data, bytes, w0, w1, wlast}
        vt[0] = '{sha256,     32'h6162_6300, 2'd3, 32'h6162_6380, 32'h0,         32'h18};
        vt[1] = '{sha512,     32'h6162_6300, 2'd3, 32'h6162_6380, 32'h0,         32'h18};
        vt[2] = '{sha1,       32'h61FF_FFFF, 2'd1, 32'h6180_0000, 32'h0,         32'h08};
        vt[3] = '{sha384,     32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 32'h8000_0000, 32'h20};
        vt[4] = '{sha224,     32'h6162_AAAA, 2'd2, 32'h6162_8000, 32'h0,         32'h10};
        vt[5] = '{sha512_256, 32'h0102_0304, 2'd0, 32'h0102_0304, 32'h8000_0000, 32'h20};
        for (int i = 0; i < 6; i++) begin
            nbytes = (vt[i].bytes == 2'd0) ? 4 : int'(vt[i].bytes);
            msg.delete();
            for (int j = 0; j < nbytes; j++) msg.push_back(vt[i].data[31 - 8*j -: 8]);
            build_model(vt[i].mode);
            send_word(vt[i].data, 1'b1, vt[i].bytes, vt[i].mode);
            lat = 0;
            while (!bus.blk_valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("vec%0d_latency_ok", i), lat <= (is_wide(vt[i].mode) ? 34 : 18), 1'b1);
            wait_blocks(1);
            if (got.size() > 0) begin
                b = got.pop_front();
                exp_d = '0;
                exp_d = put_word(exp_d, vt[i].mode, 0, vt[i].w0);
                exp_d = put_word(exp_d, vt[i].mode, 1, vt[i].w1);
                exp_d = put_word(exp_d, vt[i].mode, is_wide(vt[i].mode) ? 31 : 15, vt[i].wlast);
                if (i == 0) abc_blk = exp_d;
                check($sformatf("vec%0d_data", i), b.data, exp_d);
                check($sformatf("vec%0d_model", i), b.data, exp_blk[0]);
                check($sformatf("vec%0d_new_msg", i), b.new_msg, 1'b1);
                check($sformatf("vec%0d_mode", i), b.mode, vt[i].mode);
            end
        end

        // 56 bytes in sha256: marker fills word 14, length spills into a second block.
        msg.delete();
        for (int j = 0; j < 56; j++) msg.push_back(8'($urandom()));
        run_msg(sha256, "m56", 1'b1);
        if (rcv.size() == 2) begin
            check("m56_b1_w14", word_of(rcv[0].data, sha256, 14), 32'h8000_0000);
            check("m56_b1_w15", word_of(rcv[0].data, sha256, 15), 32'h0);
            check("m56_b2_w0", word_of(rcv[1].data, sha256, 0), 32'h0);
            check("m56_b2_w15", word_of(rcv[1].data, sha256, 15), 32'h0000_01C0);
        end

        // 33 full words in sha1: two data blocks, then the last word plus padding.
        msg.delete();
        for (int j = 0; j < 128; j++) msg.push_back(8'($urandom()));
        msg.push_back(8'h11);
        msg.push_back(8'h22);
        msg.push_back(8'h33);
        msg.push_back(8'h44);
        run_msg(sha1, "m132", 1'b1);
        if (rcv.size() == 3) begin
            check("m132_b3_w0", word_of(rcv[2].data, sha1, 0), 32'h1122_3344);
            check("m132_b3_w1", word_of(rcv[2].data, sha1, 1), 32'h8000_0000);
            check("m132_b3_w15", word_of(rcv[2].data, sha1, 15), 32'h0000_0420);
        end

        // Backpressure: block held stable and input stalled while blk_ready is low.
        rdy_mode = 0;
        @(negedge clk);
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        build_model(sha256);
        send_word(32'h6162_6300, 1'b1, 2'd3, sha256);
        lat = 0;
        while (!bus.blk_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_valid", bus.blk_valid, 1'b1);
        held = bus.blk_data;
        check("bp_held_data", held, exp_blk[0]);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp_in_ready_c%0d", c), bus.in_ready, 1'b0);
            check($sformatf("bp_stable_c%0d", c), bus.blk_data, held);
            check($sformatf("bp_valid_c%0d", c), bus.blk_valid, 1'b1);
        end
        rdy_mode = 1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", bus.in_ready, 1'b1);
        check("bp_release_valid", bus.blk_valid, 1'b0);
        wait_blocks(1);
        if (got.size() > 0) begin
            b = got.pop_front();
            check("bp_block", b.data, exp_blk[0]);
        end

        // Reset after 7 words of a sha256 message: nothing may come out.
        for (int j = 0; j < 7; j++) send_word($urandom(), 1'b0, 2'd0, sha256);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_blk_valid", bus.blk_valid, 1'b0);
        check("mid_rst_new_msg", bus.blk_new_msg, 1'b0);
        check("mid_rst_blk_data", bus.blk_data, '0);
        check("mid_rst_blk_mode", bus.blk_mode, sha1);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_block", got.size(), 0);
        send_word(32'h6162_6300, 1'b1, 2'd3, sha256);
        wait_blocks(1);
        if (got.size() > 0) begin
            b = got.pop_front();
            check("post_rst_abc", b.data, abc_blk);
            check("post_rst_new_msg", b.new_msg, 1'b1);
        end

        // Randomized messages, random modes and random block backpressure.
        rdy_mode = 2;
        for (int r = 0; r < 25; r++) begin
            rm = mode_t'($urandom_range(0, 6));
            nbytes = $urandom_range(1, 300);
            msg.delete();
            for (int j = 0; j < nbytes; j++) msg.push_back(8'($urandom()));
            run_msg(rm, $sformatf("rnd%0d", r), 1'b1);
        end
        repeat (10) @(negedge clk);
        check("no_extra_blocks", got.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
